// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and helpers for the instruction fetch unit.
//   size_t          32-bit machine word
//   ifetch_state_t  fetch FSM states (IDLE/REQ/DONE/FAULT)
//   BE_ALL          byte-enable pattern for a full-word read
//   bswap32()       reverses the byte lanes of a 32-bit word
package ifetch_pkg;

  typedef logic [31:0] size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } ifetch_state_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // Little-endian bus lanes -> big-endian word.
  function automatic size_t bswap32(input size_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/ifetch_wdog.sv
// ifetch_wdog: waitrequest watchdog for the fetch unit.
//   clk       system clock
//   reset_i   asynchronous active-low reset
//   clear     restart the count (asserted when a new read begins)
//   count_en  one stalled bus cycle is happening now
//   expired   this stalled cycle is the TIMEOUT_CYCLES-th consecutive one
// TIMEOUT_CYCLES = 0 removes the counter and never expires.
// The counter saturates at TIMEOUT_CYCLES; it never wraps back to zero.
module ifetch_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_i,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset_i, clear, count_en};
      assign expired       = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
      localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
          cnt_reg <= '0;
        end else if (clear) begin
          cnt_reg <= '0;
        end else if (count_en && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      // Flag expiry in the stall cycle that brings the count to TIMEOUT_CYCLES,
      // so the read is dropped right after exactly TIMEOUT_CYCLES stalls.
      assign expired = count_en && (cnt_reg >= CNT_LAST);
    end
  endgenerate

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit feeding the instruction register.
// Reads one 32-bit word at pc_i over an Avalon-MM read port when the control
// FSM requests it, handling waitrequest stalls, flush and misalignment.
// Ports:
//   clk, reset_i (async active-low)
//   fetch_req_i, pc_i, flush_i         control-side request
//   avm_address_o, avm_read_o, avm_byteenable_o,
//   avm_waitrequest_i, avm_readdata_i  Avalon-MM master read port
//   instr_o, instr_valid_o             fetched word and 1-cycle update pulse
//   busy_o, fault_o                    status (fault is sticky until reset)
// Build option: define IFETCH_BYTESWAP_EN to byte-swap read data into instr_o.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        fetch_req_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic [31:0] avm_address_o,
  output logic        avm_read_o,
  output logic [3:0]  avm_byteenable_o,
  input  logic        avm_waitrequest_i,
  input  logic [31:0] avm_readdata_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        busy_o,
  output logic        fault_o
);

  ifetch_state_t state_reg;
  size_t         addr_reg;
  logic          read_reg;
  size_t         rdata_reg;   // word captured at grant, committed in DONE
  size_t         instr_reg;   // last committed instruction
  logic          discard_reg; // current transfer was flushed
  logic          fault_reg;

  logic  start;
  logic  misaligned;
  logic  wdog_count;
  logic  wdog_expired;
  logic  deliver;
  size_t rdata_fmt;

  assign start      = (state_reg == IDLE) && fetch_req_i && !fault_reg;
  assign misaligned = (pc_i[1:0] != 2'b00);
  assign wdog_count = (state_reg == REQ) && avm_waitrequest_i;

`ifdef IFETCH_BYTESWAP_EN
  assign rdata_fmt = bswap32(avm_readdata_i);
`else
  assign rdata_fmt = avm_readdata_i;
`endif

  ifetch_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .reset_i (reset_i),
    .clear   (start),
    .count_en(wdog_count),
    .expired (wdog_expired)
  );

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      read_reg    <= 1'b0;
      rdata_reg   <= '0;
      instr_reg   <= '0;
      discard_reg <= 1'b0;
      fault_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (misaligned) begin
              fault_reg <= 1'b1;
              state_reg <= FAULT;
            end else begin
              addr_reg    <= pc_i;
              read_reg    <= 1'b1;
              discard_reg <= 1'b0;
              state_reg   <= REQ;
            end
          end
        end
        REQ: begin
          // A flush never aborts the bus cycle; it only marks the result as unwanted.
          if (flush_i) begin
            discard_reg <= 1'b1;
          end
          if (!avm_waitrequest_i) begin
            read_reg  <= 1'b0;
            rdata_reg <= rdata_fmt;
            state_reg <= DONE;
          end else if (wdog_expired) begin
            read_reg  <= 1'b0;
            fault_reg <= 1'b1;
            state_reg <= FAULT;
          end
        end
        DONE: begin
          if (deliver) begin
            instr_reg <= rdata_reg;
          end
          discard_reg <= 1'b0;
          state_reg   <= IDLE;
        end
        default: begin
          // FAULT: held until reset.
          read_reg <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving in DONE must still suppress the pulse, so the DONE-cycle
  // view of instr_o/instr_valid_o is gated by flush_i combinationally.
  assign deliver = (state_reg == DONE) && !discard_reg && !flush_i;

  assign instr_o          = deliver ? rdata_reg : instr_reg;
  assign instr_valid_o    = deliver;
  assign avm_address_o    = addr_reg;
  assign avm_read_o       = read_reg;
  assign avm_byteenable_o = read_reg ? BE_ALL : 4'b0000;
  assign busy_o           = (state_reg != IDLE);
  assign fault_o          = fault_reg;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: self-checking bench for ifetch. Drives directed and randomized
// fetch transactions and compares every cycle against a transaction-level
// expectation of the bus handshake and the delivered instruction.
module tb_ifetch;

  localparam int unsigned TO = 6;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        fetch_req_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] avm_address_o;
  logic        avm_read_o;
  logic [3:0]  avm_byteenable_o;
  logic        avm_waitrequest_i = 1'b0;
  logic [31:0] avm_readdata_i = '0;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        busy_o;
  logic        fault_o;

  always #5 clk = ~clk;

  ifetch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .reset_i          (reset_i),
    .fetch_req_i      (fetch_req_i),
    .pc_i             (pc_i),
    .flush_i          (flush_i),
    .avm_address_o    (avm_address_o),
    .avm_read_o       (avm_read_o),
    .avm_byteenable_o (avm_byteenable_o),
    .avm_waitrequest_i(avm_waitrequest_i),
    .avm_readdata_i   (avm_readdata_i),
    .instr_o          (instr_o),
    .instr_valid_o    (instr_valid_o),
    .busy_o           (busy_o),
    .fault_o          (fault_o)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] model_instr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus word to instruction as seen by the CPU.
  function automatic logic [31:0] bus_to_instr(input logic [31:0] d);
    logic [31:0] r;
    r = d;
`ifdef IFETCH_BYTESWAP_EN
    for (int b = 0; b < 4; b++) r[8*(3-b) +: 8] = d[8*b +: 8];
`endif
    return r;
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"}, instr_o, 32'h0);
    check({tag, "_addr"}, avm_address_o, 32'h0);
    check({tag, "_read"}, {31'b0, avm_read_o}, 32'h0);
    check({tag, "_be"}, {28'b0, avm_byteenable_o}, 32'h0);
    check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'h0);
    check({tag, "_busy"}, {31'b0, busy_o}, 32'h0);
    check({tag, "_fault"}, {31'b0, fault_o}, 32'h0);
  endtask

  // One aligned fetch: nstall waitrequest cycles, flush_at = REQ cycle index
  // carrying flush (nstall+1 means the DONE cycle, -1 means no flush).
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data,
                          input int nstall, input int flush_at);
    logic flushed;
    flushed = 1'b0;
    fetch_req_i       = 1'b1;
    pc_i              = pc;
    flush_i           = 1'($urandom_range(0, 1));
    avm_waitrequest_i = 1'($urandom_range(0, 1));
    avm_readdata_i    = $urandom;
    sample;
    check("idle_busy", {31'b0, busy_o}, 32'h0);
    check("idle_read", {31'b0, avm_read_o}, 32'h0);
    next_cycle;
    for (int i = 0; i <= nstall; i++) begin
      avm_waitrequest_i = (i < nstall);
      avm_readdata_i    = (i == nstall) ? data : $urandom;
      flush_i           = (i == flush_at);
      fetch_req_i       = 1'($urandom_range(0, 1));
      pc_i              = $urandom;
      if (flush_i) flushed = 1'b1;
      sample;
      check("req_read", {31'b0, avm_read_o}, 32'h1);
      check("req_addr", avm_address_o, pc);
      check("req_be", {28'b0, avm_byteenable_o}, 32'hF);
      check("req_valid", {31'b0, instr_valid_o}, 32'h0);
      check("req_busy", {31'b0, busy_o}, 32'h1);
      next_cycle;
    end
    avm_waitrequest_i = 1'($urandom_range(0, 1));
    avm_readdata_i    = $urandom;
    flush_i           = (flush_at == nstall + 1);
    fetch_req_i       = 1'($urandom_range(0, 1));
    if (flush_i) flushed = 1'b1;
    if (!flushed) model_instr = bus_to_instr(data);
    sample;
    check("done_valid", {31'b0, instr_valid_o}, {31'b0, !flushed});
    check("done_instr", instr_o, model_instr);
    check("done_read", {31'b0, avm_read_o}, 32'h0);
    check("done_busy", {31'b0, busy_o}, 32'h1);
    next_cycle;
    fetch_req_i = 1'b0;
    flush_i     = 1'b0;
    sample;
    check("post_instr", instr_o, model_instr);
    check("post_valid", {31'b0, instr_valid_o}, 32'h0);
    check("post_busy", {31'b0, busy_o}, 32'h0);
    check("post_read", {31'b0, avm_read_o}, 32'h0);
    $display("fetch pc=%h data=%h stall=%0d flush_at=%0d instr=%h",
             pc, data, nstall, flush_at, instr_o);
    next_cycle;
  endtask

  task automatic apply_reset;
    reset_i = 1'b0;
    repeat (2) @(posedge clk);
    sample;
    check_reset_outputs("reset");
    reset_i = 1'b1;
    model_instr = '0;
    next_cycle;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] pc;
    int          ns;
    int          fa;
    logic [31:0] swap_exp;

    apply_reset;

    // Zero-wait fetch from the boot vector.
    do_fetch(32'hBFC0_0000, 32'h2402_0005, 0, -1);
    // Five stall cycles.
    do_fetch(32'hBFC0_0004, 32'h1234_5678, 5, -1);
    // Flush in REQ during a 3-cycle stall, then a normal fetch.
    do_fetch(32'hBFC0_0008, 32'hDEAD_BEEF, 3, 1);
    do_fetch(32'hBFC0_000C, 32'h0A0B_0C0D, 1, -1);
    // Flush in the grant cycle and in DONE.
    do_fetch(32'hBFC0_0010, 32'h1111_2222, 2, 2);
    do_fetch(32'hBFC0_0014, 32'h3333_4444, 2, 3);

    // Lane order of the delivered word.
    do_fetch(32'h0000_0100, 32'h0500_0224, 0, -1);
`ifdef IFETCH_BYTESWAP_EN
    swap_exp = 32'h2402_0005;
`else
    swap_exp = 32'h0500_0224;
`endif
    check("lane_order", instr_o, swap_exp);

    for (int n = 0; n < 30; n++) begin
      r  = $urandom;
      pc = {r[31:2], 2'b00};
      ns = $urandom_range(0, TO - 1);
      fa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ns + 1) : -1;
      do_fetch(pc, $urandom, ns, fa);
    end

    // Reset asserted in the middle of a stalled read.
    fetch_req_i = 1'b1;
    pc_i        = 32'h0000_2000;
    avm_waitrequest_i = 1'b1;
    next_cycle;
    fetch_req_i = 1'b0;
    next_cycle;
    #2;
    reset_i = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    model_instr = '0;
    avm_waitrequest_i = 1'b0;
    next_cycle;

    // Misaligned pc: straight to fault, no bus access, sticky.
    fetch_req_i = 1'b1;
    pc_i        = 32'h0000_0006;
    sample;
    check("mis_busy0", {31'b0, busy_o}, 32'h0);
    next_cycle;
    fetch_req_i = 1'b0;
    sample;
    check("mis_fault", {31'b0, fault_o}, 32'h1);
    check("mis_read", {31'b0, avm_read_o}, 32'h0);
    check("mis_busy", {31'b0, busy_o}, 32'h1);
    next_cycle;
    for (int n = 0; n < 5; n++) begin
      fetch_req_i = 1'b1;
      r    = $urandom;
      pc_i = {r[31:2], 2'b00};
      sample;
      check("mis_sticky", {31'b0, fault_o}, 32'h1);
      check("mis_noread", {31'b0, avm_read_o}, 32'h0);
      check("mis_instr", instr_o, model_instr);
      next_cycle;
    end
    fetch_req_i = 1'b0;

    apply_reset;

    // Watchdog: waitrequest stuck high.
    fetch_req_i = 1'b1;
    pc_i        = 32'h0000_4000;
    avm_waitrequest_i = 1'b1;
    next_cycle;
    fetch_req_i = 1'b0;
    for (int n = 0; n < int'(TO); n++) begin
      sample;
      check("wd_read", {31'b0, avm_read_o}, 32'h1);
      check("wd_nofault", {31'b0, fault_o}, 32'h0);
      next_cycle;
    end
    sample;
    check("wd_drop", {31'b0, avm_read_o}, 32'h0);
    check("wd_fault", {31'b0, fault_o}, 32'h1);
    check("wd_busy", {31'b0, busy_o}, 32'h1);
    next_cycle;
    sample;
    check("wd_stay", {31'b0, avm_read_o}, 32'h0);
    check("wd_valid", {31'b0, instr_valid_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
